// File: rtl/lc4_muldiv_seq_pkg.sv
// Shared types and LC4 decode constants for the MUL/DIV/MOD sequencer.
package lc4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  localparam logic [3:0] OP_ARITH = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b1010;
  localparam logic [2:0] SUB_MUL  = 3'b001;
  localparam logic [2:0] SUB_DIV  = 3'b011;
  localparam logic [1:0] SHF_MOD  = 2'b11;

  function automatic logic dec_is_mul(input logic [3:0] op, input logic [2:0] sub);
    return (op == OP_ARITH) && (sub == SUB_MUL);
  endfunction

  function automatic logic dec_is_div(input logic [3:0] op, input logic [2:0] sub);
    return (op == OP_ARITH) && (sub == SUB_DIV);
  endfunction

  function automatic logic dec_is_mod(input logic [3:0] op, input logic [1:0] shf);
    return (op == OP_SHIFT) && (shf == SHF_MOD);
  endfunction

endpackage

// File: rtl/lc4_muldiv_seq_if.sv
// Handshake/data bundle between the execute stage and the MUL/DIV/MOD sequencer.
interface lc4_muldiv_seq_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic [15:0]          i_insn;
  logic [WORD_SIZE-1:0] i_r1data;
  logic [WORD_SIZE-1:0] i_r2data;
  logic                 i_flush;
  logic                 o_busy;
  logic                 o_valid;
  logic [WORD_SIZE-1:0] o_result;
  logic                 i_ack;

  modport master (
    output i_valid, i_insn, i_r1data, i_r2data, i_flush, i_ack,
    input  o_ready, o_busy, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_insn, i_r1data, i_r2data, i_flush, i_ack,
    output o_ready, o_busy, o_valid, o_result
  );
endinterface

// File: rtl/lc4_muldiv_seq_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module lc4_muldiv_step
  import lc4_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  step_mode_e           mode_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  input  logic [WORD_SIZE-1:0] c_i,
  output logic [WORD_SIZE-1:0] a_o,
  output logic [WORD_SIZE-1:0] b_o,
  output logic [WORD_SIZE-1:0] c_o
);
  // MUL: a=accumulator, b=multiplicand (shifts left), c=multiplier (shifts right).
  // DIV: a=remainder, b=divisor, c=dividend shifting out MSB-first / quotient shifting in.
  logic [WORD_SIZE:0]   rem_sh;
  logic [WORD_SIZE+1:0] diff;
  logic                 unused_diff_bit;

  assign unused_diff_bit = diff[WORD_SIZE];

  always_comb begin
    a_o    = a_i;
    b_o    = b_i;
    c_o    = c_i;
    rem_sh = {a_i, c_i[WORD_SIZE-1]};
    diff   = {1'b0, rem_sh} - {2'b00, b_i};
    if (mode_i == STEP_MUL) begin
      if (c_i[0]) begin
        a_o = a_i + b_i;
      end
      b_o = b_i << 1;
      c_o = c_i >> 1;
    end else begin
      // Remainder stays below the divisor, so the low WORD_SIZE bits hold it exactly.
      if (!diff[WORD_SIZE+1]) begin
        a_o = diff[WORD_SIZE-1:0];
        c_o = {c_i[WORD_SIZE-2:0], 1'b1};
      end else begin
        a_o = rem_sh[WORD_SIZE-1:0];
        c_o = {c_i[WORD_SIZE-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/lc4_muldiv_seq.sv
// Multi-cycle LC4 MUL/DIV/MOD sequencer. Optional macro LC4_MULDIV_EARLY_EXIT_EN
// lets MUL finish as soon as the remaining multiplier bits are all zero.
module lc4_muldiv_seq
  import lc4_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input logic                clk,
  input logic                rst,
  lc4_muldiv_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(WORD_SIZE);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 is_mod_q, is_mod_d;

  step_mode_e           step_mode;
  logic [WORD_SIZE-1:0] a_s, b_s, c_s;
  logic                 dec_mul, dec_div, dec_mod, last_iter, mul_done;
  logic                 unused_insn;

  assign dec_mul     = dec_is_mul(bus.i_insn[15:12], bus.i_insn[5:3]);
  assign dec_div     = dec_is_div(bus.i_insn[15:12], bus.i_insn[5:3]);
  assign dec_mod     = dec_is_mod(bus.i_insn[15:12], bus.i_insn[5:4]);
  assign unused_insn = ^{bus.i_insn[11:6], bus.i_insn[2:0]};
  assign last_iter   = (cnt_q == CNT_W'(WORD_SIZE - 1));
  assign step_mode   = (state_q == MUL) ? STEP_MUL : STEP_DIV;

`ifdef LC4_MULDIV_EARLY_EXIT_EN
  assign mul_done = last_iter || (c_s == '0);
`else
  assign mul_done = last_iter;
`endif

  lc4_muldiv_step #(.WORD_SIZE(WORD_SIZE)) u_step (
    .mode_i (step_mode),
    .a_i    (a_q),
    .b_i    (b_q),
    .c_i    (c_q),
    .a_o    (a_s),
    .b_o    (b_s),
    .c_o    (c_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    is_mod_d = is_mod_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid && (dec_mul || dec_div || dec_mod)) begin
          a_d   = '0;
          cnt_d = '0;
          if (dec_mul) begin
            b_d     = bus.i_r1data;
            c_d     = bus.i_r2data;
            state_d = MUL;
`ifdef LC4_MULDIV_EARLY_EXIT_EN
            if (bus.i_r2data == '0) begin
              state_d  = DONE;
              result_d = '0;
            end
`endif
          end else begin
            b_d      = bus.i_r2data;
            c_d      = bus.i_r1data;
            is_mod_d = dec_mod;
            if (bus.i_r2data == '0) begin
              state_d  = DONE;
              result_d = '0;
            end else begin
              state_d = DIV;
            end
          end
        end
      end
      MUL: begin
        a_d   = a_s;
        b_d   = b_s;
        c_d   = c_s;
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          state_d  = DONE;
          result_d = a_s;
        end
      end
      DIV: begin
        a_d   = a_s;
        b_d   = b_s;
        c_d   = c_s;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = DONE;
          result_d = is_mod_q ? a_s : c_s;
        end
      end
      DONE: begin
        if (bus.i_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a result that would land this edge.
    if (bus.i_flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      is_mod_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      is_mod_q <= is_mod_d;
    end
  end

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_lc4_muldiv_seq.sv
// Randomized self-checking bench for lc4_muldiv_seq against a plain-arithmetic model.
module tb_lc4_muldiv_seq;
  localparam int W = 16;

  typedef enum int {K_MUL, K_DIV, K_MOD} kind_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc4_muldiv_seq_if #(.WORD_SIZE(W)) bus();
  lc4_muldiv_seq #(.WORD_SIZE(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_result = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_insn(input kind_e k);
    logic [2:0] rd, rs, rt;
    logic [3:0] rt4;
    rd  = 3'($urandom);
    rs  = 3'($urandom);
    rt  = 3'($urandom);
    rt4 = 4'($urandom);
    case (k)
      K_MUL:   return {4'b0001, rd, rs, 3'b001, rt};
      K_DIV:   return {4'b0001, rd, rs, 3'b011, rt};
      default: return {4'b1010, rd, rs, 2'b11, rt4};
    endcase
  endfunction

  function automatic logic [W-1:0] ref_result(input kind_e k, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned p;
    case (k)
      K_MUL: begin
        p = longint'(a) * longint'(b);
        return p[W-1:0];
      end
      K_DIV:   return (b == 0) ? '0 : a / b;
      default: return (b == 0) ? '0 : a % b;
    endcase
  endfunction

  // Edges after the accepting edge until DONE is visible.
  function automatic int ref_latency(input kind_e k, input logic [W-1:0] b);
    int h;
    if (k != K_MUL) return (b == 0) ? 0 : W;
`ifdef LC4_MULDIV_EARLY_EXIT_EN
    if (b == 0) return 0;
    h = 0;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return h + 1;
`else
    h = W;
    return h;
`endif
  endfunction

  task automatic issue(input logic [15:0] insn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_insn   = insn;
    bus.i_r1data = a;
    bus.i_r2data = b;
    chk("ready_before_accept", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid  = 1'b0;
    bus.i_insn   = 16'($urandom);
    bus.i_r1data = W'($urandom);
    bus.i_r2data = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp_res, input int exp_lat);
    int edges;
    edges = 0;
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
    chk({tag, "_not_ready"}, 32'(bus.o_ready), 32'd0);
    while (bus.o_valid !== 1'b1 && edges < W + 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, "_result"}, 32'(bus.o_result), 32'(exp_res));
  endtask

  task automatic hold_and_ack(input string tag, input logic [W-1:0] exp_res, input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(bus.o_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(bus.o_result), 32'(exp_res));
    end
    @(negedge clk);
    bus.i_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ack = 1'b0;
    chk({tag, "_ack_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_ack_ready"}, 32'(bus.o_ready), 32'd1);
    chk({tag, "_ack_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_ack_result_held"}, 32'(bus.o_result), 32'(exp_res));
    last_result = exp_res;
  endtask

  task automatic run_op(input string tag, input kind_e k, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] exp_res;
    int           exp_lat;
    exp_res = ref_result(k, a, b);
    exp_lat = ref_latency(k, b);
    issue(mk_insn(k), a, b);
    wait_done(tag, exp_res, exp_lat);
    $display("op %s %s a=0x%04h b=0x%04h expect=0x%04h got=0x%04h lat=%0d",
             tag, k.name(), a, b, exp_res, bus.o_result, exp_lat);
    hold_and_ack(tag, exp_res, hold);
  endtask

  initial begin
    logic         saw_valid;
    kind_e        k;
    logic [W-1:0] ra, rb;

    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_insn   = '0;
    bus.i_r1data = '0;
    bus.i_r2data = '0;
    bus.i_flush  = 1'b0;
    bus.i_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.o_ready), 32'd1);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_result", 32'(bus.o_result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_7x6", K_MUL, 16'd7, 16'd6, 1);
    run_op("mul_wrap", K_MUL, 16'h0100, 16'h0100, 0);
    run_op("mul_ffff_x2", K_MUL, 16'hFFFF, 16'h0002, 0);
    run_op("div_100_7", K_DIV, 16'd100, 16'd7, 0);
    run_op("mod_100_7", K_MOD, 16'd100, 16'd7, 0);
    run_op("div_ffff_1", K_DIV, 16'hFFFF, 16'h0001, 0);
    run_op("div_by0", K_DIV, 16'h1234, 16'h0000, 0);
    run_op("mod_by0", K_MOD, 16'h1234, 16'h0000, 0);
    run_op("mul_by0", K_MUL, 16'h1234, 16'h0000, 0);

    // Non-MUL/DIV/MOD instruction must not be accepted.
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_insn   = 16'b0001_000_001_000_010;
    bus.i_r1data = 16'd3;
    bus.i_r2data = 16'd4;
    @(posedge clk);
    #1;
    bus.i_insn = 16'b1010_000_001_00_0010;
    chk("ignore_add_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("ignore_sll_busy", 32'(bus.o_busy), 32'd0);
    chk("ignore_sll_ready", 32'(bus.o_ready), 32'd1);
    $display("op ignore_non_muldiv busy=%0b ready=%0b", bus.o_busy, bus.o_ready);

    // Flush during iteration 5 of a MUL.
    issue(mk_insn(K_MUL), 16'h1234, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("flush_ready", 32'(bus.o_ready), 32'd1);
    chk("flush_busy", 32'(bus.o_busy), 32'd0);
    chk("flush_valid", 32'(bus.o_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    chk("flush_no_valid", 32'(saw_valid), 32'd0);
    chk("flush_result_held", 32'(bus.o_result), 32'(last_result));
    $display("op flush_mul result_held=0x%04h", bus.o_result);
    run_op("div_after_flush", K_DIV, 16'd1000, 16'd33, 0);

    // Reset during iteration 5 of a MUL.
    issue(mk_insn(K_MUL), 16'h4321, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", 32'(bus.o_result), 32'd0);
    last_result = '0;
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    chk("rst_no_valid", 32'(saw_valid), 32'd0);
    $display("op reset_mul result=0x%04h", bus.o_result);
    run_op("mod_after_rst", K_MOD, 16'd1000, 16'd33, 0);

    // Hold 3 cycles, then ack together with a new offer: accepted one cycle later.
    issue(mk_insn(K_DIV), 16'd5000, 16'd77);
    wait_done("ackv_div", ref_result(K_DIV, 16'd5000, 16'd77), ref_latency(K_DIV, 16'd77));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ackv_hold_result", 32'(bus.o_result), 32'(ref_result(K_DIV, 16'd5000, 16'd77)));
    end
    @(negedge clk);
    bus.i_ack    = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_insn   = mk_insn(K_MUL);
    bus.i_r1data = 16'd7;
    bus.i_r2data = 16'd6;
    @(posedge clk);
    #1;
    bus.i_ack = 1'b0;
    chk("ackv_not_accepted_busy", 32'(bus.o_busy), 32'd0);
    chk("ackv_not_accepted_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    $display("op ack_with_valid second_offer_busy=%0b", bus.o_busy);
    wait_done("ackv_mul", 16'h002A, ref_latency(K_MUL, 16'd6));
    hold_and_ack("ackv_mul", 16'h002A, 0);

    for (int i = 0; i < 40; i++) begin
      k  = kind_e'($urandom_range(0, 2));
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), k, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lc4_muldiv_seq.md
# lc4_muldiv_seq

Multi-cycle sequencer for the LC4 MUL, DIV and MOD operations, which the single-cycle ALU does not compute. It sits beside the ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and drives a stall while it iterates. It holds the result until the pipeline acknowledges it.

## Interface
- WORD_SIZE, 16, datapath width in bits; same meaning as the ALU's WORD_SIZE.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  an operation is offered this cycle.
- o_ready  out  1  sequencer can accept; high only in IDLE.
- i_insn  in  16  LC4 instruction word of the offered operation.
- i_r1data  in  WORD_SIZE  first operand (Rs).
- i_r2data  in  WORD_SIZE  second operand (Rt).
- i_flush  in  1  abort any operation in flight (branch mispredict or exception).
- o_busy  out  1  stall request to the pipeline; high in MUL, DIV and DONE.
- o_valid  out  1  o_result is valid.
- o_result  out  WORD_SIZE  result.
- i_ack  in  1  consumer takes the result while o_valid is high.

## Operation
- Decode:
  - MUL: i_insn[15:12]==4'b0001 && i_insn[5:3]==3'b001.
  - DIV: i_insn[15:12]==4'b0001 && i_insn[5:3]==3'b011.
  - MOD: i_insn[15:12]==4'b1010 && i_insn[5:4]==2'b11.
  - Any other i_insn offered with i_valid is ignored and not accepted; the sequencer stays in IDLE.
- Arithmetic:
  - All operations are unsigned.
  - MUL keeps the low WORD_SIZE bits of the product; it uses shift-add on one multiplier bit per cycle, LSB first.
  - DIV and MOD use restoring division, one quotient bit per cycle, MSB first, with a WORD_SIZE+1-bit partial remainder.
  - DIV returns the quotient; MOD returns the remainder.
  - Divisor 0: both DIV and MOD return 0.
- States: IDLE, MUL, DIV, DONE. MOD shares the DIV state and sets a result-select flag.
  - IDLE: a decoded MUL with i_valid goes to MUL. A decoded DIV or MOD goes to DIV, or straight to DONE with result 0 if i_r2data==0. Operands are latched on acceptance.
  - MUL or DIV: an iteration counter runs from 0 to WORD_SIZE-1. After the last iteration the state goes to DONE.
  - DONE: o_valid is high. i_ack returns the state to IDLE; otherwise the state and o_result are held.
- i_flush: in any state the next state is IDLE and o_valid drops. Flush beats i_ack and beats a new i_valid in the same cycle. In IDLE, flush also blocks acceptance that cycle.
- The sequencer never accepts a new operation in the same cycle as i_ack. It returns to IDLE first.

## Timing
- Reset values: state IDLE, o_ready=1, o_busy=0, o_valid=0, o_result=0, counter=0.
- rst mid-operation: the operation is discarded and every output returns to its reset value on the next edge.
- Acceptance happens at edge T. o_busy is high from T+1 until the edge at which DONE is left.
- MUL, DIV and MOD: the state is in DONE (o_valid=1) from cycle T+WORD_SIZE+1, i.e. cycle T+17 at WORD_SIZE=16.
- Division by zero: o_valid=1 at T+1.
- o_result changes only on entering DONE. It holds its value after leaving DONE until the next result.
- o_ready and o_busy are decoded from registered state with no combinational path from any input. o_ready is not a function of i_valid.

## Configuration
- LC4_MULDIV_EARLY_EXIT_EN:
  - Defined: MUL goes to DONE at the first edge where the remaining shifted multiplier is zero, so latency is 1 plus the index of the highest set bit of Rt, plus 1. A MUL with Rt==0 reaches DONE at T+1. DIV and MOD are unchanged.
  - Undefined: MUL always takes the full WORD_SIZE iterations.

## Structure
- Shared package `lc4_pkg` holds:
  - the state enum;
  - opcode constants OP_ARITH=4'b0001 and OP_SHIFT=4'b1010;
  - sub-op constants SUB_MUL=3'b001, SUB_DIV=3'b011 and SHF_MOD=2'b11.
- One sub-module, `lc4_muldiv_step`: a combinational single iteration (shift-add step or restore-subtract step) selected by mode. The sequencer owns all registers and the FSM.

## Test plan
- MUL with Rs=7 and Rt=6, WORD_SIZE=16 -> o_valid at T+17 with o_result=0x002A; o_busy high T+1..T+17 until ack.
- MUL with Rs=0x0100 and Rt=0x0100 -> o_result=0x0000 (wrap). Rs=0xFFFF and Rt=0x0002 -> 0xFFFE.
- DIV of 100 by 7 -> 0x000E. MOD of 100 by 7 -> 0x0002. DIV of 0xFFFF by 0x0001 -> 0xFFFF.
- DIV and MOD with Rt=0 -> o_valid at T+1 with o_result=0.
- i_flush at iteration 5 of a MUL -> IDLE next edge, o_valid never rises; an immediately following DIV completes correctly. Repeat with rst instead of i_flush and check the reset values.
- o_valid held 3 cycles without i_ack -> result stable. Then i_ack together with a new i_valid -> the new operation is not accepted that cycle; it is accepted on the following cycle.
